// File: rtl/peak_counter_readout_ctrl.sv
// peak_counter_readout_ctrl: runs one peak-counter measurement and streams the framed result
// Ports: clk/rst (async active-low); start_in, abort_in, window_len_in control a run;
// count_in/overflow_in come from the datapath, which is driven by cntr_clr_out,
// counter_clk_en_out, sreg_load_en_out, sreg_shift_en_out; dout/dout_vld/dout_rdy
// form the byte stream; busy_out spans CLEAR..frame end, done_out pulses at the end.
module peak_counter_readout_ctrl #(
  parameter int CNTR_DEPTH = 24,
  parameter int CNTR_WIDTH = 8,
  parameter int WINDOW_WIDTH = 32,
  parameter logic [CNTR_WIDTH-1:0] SYNC_WORD = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_in,
  input  logic                    abort_in,
  input  logic [WINDOW_WIDTH-1:0] window_len_in,
  input  logic [CNTR_WIDTH-1:0]   count_in,
  input  logic [CNTR_DEPTH-1:0]   overflow_in,
  output logic                    cntr_clr_out,
  output logic                    counter_clk_en_out,
  output logic                    sreg_load_en_out,
  output logic                    sreg_shift_en_out,
  output logic [CNTR_WIDTH-1:0]   dout,
  output logic                    dout_vld,
  input  logic                    dout_rdy,
  output logic                    busy_out,
  output logic                    done_out
);
  localparam int OVF_WORDS = (CNTR_DEPTH + CNTR_WIDTH - 1) / CNTR_WIDTH;
  localparam int IW = $clog2(CNTR_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, LOAD, HDR, CNT, OVF, DONE} state_t;
  state_t state, nxt;
  logic [WINDOW_WIDTH-1:0] win;
  logic [IW-1:0] idx, nidx;
  logic [CNTR_DEPTH-1:0] ovf_q;
  logic [OVF_WORDS*CNTR_WIDTH-1:0] ovf_pad;
  logic [CNTR_WIDTH-1:0] dout_q;
  logic acc, last;
  assign acc = dout_vld & dout_rdy;
  // zero-extension makes flag bits above CNTR_DEPTH read as 0
  assign ovf_pad = (OVF_WORDS*CNTR_WIDTH)'(ovf_q);
  // only the count words bypass the output register so they track the shift register
  assign dout = state == CNT ? count_in : dout_q;
  assign sreg_shift_en_out = (state == CNT) & dout_rdy;
  always_comb begin
    last = state == CNT ? idx == IW'(CNTR_DEPTH - 1) : idx == IW'(OVF_WORDS - 1);
    nxt = state;
    case (state)
      IDLE:    nxt = start_in ? CLEAR : IDLE;
      CLEAR:   nxt = win == '0 ? LOAD : COUNT;
      COUNT:   nxt = win == WINDOW_WIDTH'(1) ? LOAD : COUNT;
      LOAD:    nxt = HDR;
      HDR:     nxt = acc ? CNT : HDR;
      CNT:     nxt = acc && last ? OVF : CNT;
      OVF:     nxt = acc && last ? DONE : OVF;
      default: nxt = IDLE;
    endcase
    if (abort_in) nxt = IDLE;
    nidx = (abort_in || !(state == CNT || state == OVF)) ? '0 : acc ? (last ? '0 : idx + IW'(1)) : idx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      win <= '0;
      ovf_q <= '0;
      dout_q <= '0;
      cntr_clr_out <= 1'b0;
      counter_clk_en_out <= 1'b0;
      sreg_load_en_out <= 1'b0;
      dout_vld <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      state <= nxt;
      idx <= nidx;
      win <= abort_in ? '0 : (state == IDLE && start_in) ? window_len_in : state == COUNT ? win - WINDOW_WIDTH'(1) : win;
      if (state == LOAD) ovf_q <= overflow_in;
      dout_q <= nxt == HDR ? SYNC_WORD : nxt == OVF ? CNTR_WIDTH'(ovf_pad >> (nidx * CNTR_WIDTH)) : '0;
      cntr_clr_out <= nxt == CLEAR;
      counter_clk_en_out <= nxt == COUNT;
      sreg_load_en_out <= nxt == LOAD;
      dout_vld <= nxt inside {HDR, CNT, OVF};
      busy_out <= !(nxt inside {IDLE, DONE});
      done_out <= nxt == DONE;
    end
  end
endmodule
